pipe_front_ctrl: RTL and testbench
==================================

Name: pipe_front_ctrl

Overview:
- Consumer end of the stall interface driven by the hazard detection logic.
- Owns the PC register, the IF/ID pipeline register and the ID/EX control/destination register.
- Applies pc_keep / if_id_keep / id_ex_zero, branch redirect/flush and instruction-memory wait states.
- Feeds ex_rt/ex_rd/ex_mem_read back to the hazard logic.

Parameters:
- ADDR_W, 32, PC / instruction address width.
- INSTR_W, 32, instruction width.
- CTRL_W, 8, ID-stage control bundle width; bit 0 = mem_read, bit 1 = reg_write.
- REG_W, 5, register index width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- pc_keep_i  in  1  hold PC this cycle.
- if_id_keep_i  in  1  hold IF/ID this cycle.
- id_ex_zero_i  in  1  load bubble (zero control) into ID/EX.
- branch_taken_i  in  1  ID-stage branch resolved taken.
- branch_target_i  in  ADDR_W  redirect address.
- imem_ready_i  in  1  imem_rdata_i valid for imem_addr_o this cycle.
- imem_rdata_i  in  INSTR_W  fetched instruction.
- id_ctrl_i  in  CTRL_W  decoded control for the instruction in ID.
- id_rt_i  in  REG_W  rt of the ID instruction.
- id_rd_i  in  REG_W  write-destination index of the ID instruction.
- imem_addr_o  out  ADDR_W  equals pc_o (combinational).
- pc_o  out  ADDR_W  current PC.
- if_id_instr_o  out  INSTR_W  IF/ID instruction.
- if_id_pc4_o  out  ADDR_W  IF/ID PC+4.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- ex_ctrl_o  out  CTRL_W  ID/EX control.
- ex_rt_o  out  REG_W  ID/EX rt.
- ex_rd_o  out  REG_W  ID/EX destination.
- ex_mem_read_o  out  1  equals ex_ctrl_o[0].
- ex_reg_write_o  out  1  equals ex_ctrl_o[1].
- fetch_wait_o  out  1  FSM in WAIT.

Behaviour:
- Reset (rst_n_i=0 at edge, overrides everything):
  - pc_o=RESET_PC.
  - IF/ID instr/pc4/valid = 0.
  - ex_ctrl/rt/rd = 0.
  - FSM=RUN.
- FSM states:
  - RUN→WAIT when imem_ready_i=0 and pc_keep_i=0.
  - WAIT→RUN when imem_ready_i=1, or on redirect.
  - fetch_wait_o=1 only in WAIT.
- PC update priority, evaluated each edge:
  - 1) pc_keep_i=1: hold. branch_taken_i is ignored; the hazard logic only stalls when branch operands are unready.
  - 2) branch_taken_i=1: load branch_target_i, regardless of imem_ready_i; the abandoned fetch is discarded.
  - 3) imem_ready_i=0: hold.
  - 4) otherwise pc+4, modulo 2^ADDR_W (0xFFFFFFFC→0).
- IF/ID update priority:
  - 1) if_id_keep_i=1: hold all fields.
  - 2) branch_taken_i=1: flush; instr=0 (nop), valid=0, pc4=0.
  - 3) imem_ready_i=0: bubble; instr=0, valid=0.
  - 4) otherwise instr=imem_rdata_i, pc4=pc_o+4, valid=1.
- ID/EX update:
  - id_ex_zero_i=1 or if_id_valid_o=0: ctrl=0, rt=0, rd=0.
  - Otherwise capture id_ctrl_i, id_rt_i, id_rd_i.
  - ID/EX is never held; latency 1 cycle.
- Simultaneous events:
  - pc_keep_i without if_id_keep_i: legal; IF/ID still follows rules 2-4.
  - keep + zero together (the normal stall): exactly one bubble per asserted cycle.
- Reset mid-WAIT: returns to RUN with PC=RESET_PC next cycle.

Optional Feature:
- Macro FRONT_STALL_CNT_EN.
- Defined:
  - Adds outputs stall_cnt_o[31:0] (cycles with pc_keep_i=1), bubble_cnt_o[31:0] (cycles ID/EX loaded zero) and flush_cnt_o[31:0] (cycles IF/ID flushed by branch).
  - All three cleared by reset and saturate at 0xFFFFFFFF.
- Not defined: ports and counters are absent, with no other change.

Test Plan:
- Reset with RESET_PC=0x100, then imem_ready_i=1 for 3 cycles → pc_o 0x100,0x104,0x108,0x10C; if_id_valid_o=1 from the first edge; if_id_pc4_o=0x104 first.
- Load-use stall: pc_keep_i=if_id_keep_i=id_ex_zero_i=1 for 1 cycle at pc=0x108 → pc_o stays 0x108, IF/ID unchanged, ex_ctrl_o=0; next cycle resumes at 0x10C.
- branch_taken_i=1, target 0x40 → next pc_o=0x40, if_id_valid_o=0, if_id_instr_o=0; with pc_keep_i=1 the same cycle → PC held, branch ignored.
- imem_ready_i=0 for 2 cycles → fetch_wait_o=1 for 2 cycles, PC held, 2 bubbles in IF/ID, then normal fetch.
- pc=0xFFFFFFFC, ready → wraps to 0x0; rst_n_i=0 during WAIT → PC=RESET_PC, fetch_wait_o=0 next cycle.
- FRONT_STALL_CNT_EN: 3 stall cycles + 1 flush → stall_cnt_o=3, bubble_cnt_o≥3, flush_cnt_o=1.

Source files
------------

// File: rtl/pipe_front_ctrl.sv
// pipe_front_ctrl: PC, IF/ID and ID/EX registers driven by stall, flush and imem wait controls.
// Optional FRONT_STALL_CNT_EN adds saturating stall/bubble/flush event counters.
module pipe_front_ctrl #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int CTRL_W = 8,
  parameter int REG_W = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pc_keep_i,
  input  logic               if_id_keep_i,
  input  logic               id_ex_zero_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic [CTRL_W-1:0]  id_ctrl_i,
  input  logic [REG_W-1:0]   id_rt_i,
  input  logic [REG_W-1:0]   id_rd_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o,
  output logic               if_id_valid_o,
  output logic [CTRL_W-1:0]  ex_ctrl_o,
  output logic [REG_W-1:0]   ex_rt_o,
  output logic [REG_W-1:0]   ex_rd_o,
  output logic               ex_mem_read_o,
  output logic               ex_reg_write_o,
`ifdef FRONT_STALL_CNT_EN
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        bubble_cnt_o,
  output logic [31:0]        flush_cnt_o,
`endif
  output logic               fetch_wait_o
);
  typedef enum logic {RUN, WAIT} state_t;
  state_t state, state_nxt;
  logic redirect, ex_zero;
  logic [ADDR_W-1:0] pc4;
  assign pc4 = pc_o + ADDR_W'(4);
  // a taken branch only redirects when the PC is not being held
  assign redirect = branch_taken_i & ~pc_keep_i;
  assign ex_zero = id_ex_zero_i | ~if_id_valid_o;
  assign imem_addr_o = pc_o;
  assign ex_mem_read_o = ex_ctrl_o[0];
  assign ex_reg_write_o = ex_ctrl_o[1];
  always_comb begin
    state_nxt = state;
    if (state == RUN) state_nxt = (!imem_ready_i && !pc_keep_i && !redirect) ? WAIT : RUN;
    else state_nxt = (imem_ready_i || redirect) ? RUN : WAIT;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      fetch_wait_o <= 1'b0;
      pc_o <= RESET_PC;
      if_id_instr_o <= '0;
      if_id_pc4_o <= '0;
      if_id_valid_o <= 1'b0;
      ex_ctrl_o <= '0;
      ex_rt_o <= '0;
      ex_rd_o <= '0;
    end else begin
      state <= state_nxt;
      fetch_wait_o <= state_nxt == WAIT;
      pc_o <= pc_keep_i ? pc_o : branch_taken_i ? branch_target_i : imem_ready_i ? pc4 : pc_o;
      if (!if_id_keep_i) begin
        if_id_instr_o <= (branch_taken_i || !imem_ready_i) ? '0 : imem_rdata_i;
        if_id_valid_o <= !branch_taken_i && imem_ready_i;
        if_id_pc4_o <= branch_taken_i ? '0 : imem_ready_i ? pc4 : if_id_pc4_o;
      end
      ex_ctrl_o <= ex_zero ? '0 : id_ctrl_i;
      ex_rt_o <= ex_zero ? '0 : id_rt_i;
      ex_rd_o <= ex_zero ? '0 : id_rd_i;
    end
  end
`ifdef FRONT_STALL_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      bubble_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(pc_keep_i && stall_cnt_o != '1);
      bubble_cnt_o <= bubble_cnt_o + 32'(ex_zero && bubble_cnt_o != '1);
      flush_cnt_o <= flush_cnt_o + 32'(branch_taken_i && !if_id_keep_i && flush_cnt_o != '1);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_front_ctrl.sv
// tb_pipe_front_ctrl: directed vectors for pipe_front_ctrl with hand-computed expectations.
module tb_pipe_front_ctrl;
  logic clk = 0, rst_n = 0;
  logic pc_keep = 0, if_id_keep = 0, id_ex_zero = 0, branch_taken = 0, imem_ready = 1;
  logic [31:0] branch_target = 0, imem_rdata, imem_addr, pc, if_id_instr, if_id_pc4;
  logic [7:0] id_ctrl = 8'h03, ex_ctrl;
  logic [4:0] id_rt = 5'd5, id_rd = 5'd7, ex_rt, ex_rd;
  logic if_id_valid, ex_mem_read, ex_reg_write, fetch_wait;
  int tests = 0, fails = 0;
`ifdef FRONT_STALL_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
`endif
  always #5 clk = ~clk;
  // instruction word derived from the fetch address so captures are traceable
  assign imem_rdata = 32'hA5A50000 | {16'h0, imem_addr[15:0]};
  pipe_front_ctrl #(.RESET_PC(32'h100)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pc_keep_i(pc_keep), .if_id_keep_i(if_id_keep),
    .id_ex_zero_i(id_ex_zero), .branch_taken_i(branch_taken), .branch_target_i(branch_target),
    .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata), .id_ctrl_i(id_ctrl),
    .id_rt_i(id_rt), .id_rd_i(id_rd), .imem_addr_o(imem_addr), .pc_o(pc),
    .if_id_instr_o(if_id_instr), .if_id_pc4_o(if_id_pc4), .if_id_valid_o(if_id_valid),
    .ex_ctrl_o(ex_ctrl), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd), .ex_mem_read_o(ex_mem_read),
    .ex_reg_write_o(ex_reg_write),
`ifdef FRONT_STALL_CNT_EN
    .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt),
`endif
    .fetch_wait_o(fetch_wait)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    chk("rst_pc", pc, 32'h100);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_instr", if_id_instr, 0);
    chk("rst_ctrl", 32'(ex_ctrl), 0);
    chk("rst_wait", 32'(fetch_wait), 0);
    rst_n = 1;
    step();
    chk("f1_pc", pc, 32'h104);
    chk("f1_valid", 32'(if_id_valid), 1);
    chk("f1_pc4", if_id_pc4, 32'h104);
    chk("f1_instr", if_id_instr, 32'hA5A50100);
    chk("f1_ctrl", 32'(ex_ctrl), 0);
    step();
    chk("f2_pc", pc, 32'h108);
    chk("f2_instr", if_id_instr, 32'hA5A50104);
    chk("f2_ctrl", 32'(ex_ctrl), 32'h03);
    chk("f2_rt", 32'(ex_rt), 5);
    chk("f2_rd", 32'(ex_rd), 7);
    chk("f2_mr", 32'(ex_mem_read), 1);
    chk("f2_rw", 32'(ex_reg_write), 1);
    pc_keep = 1; if_id_keep = 1; id_ex_zero = 1;
    step();
    chk("stall_pc", pc, 32'h108);
    chk("stall_pc4", if_id_pc4, 32'h108);
    chk("stall_instr", if_id_instr, 32'hA5A50104);
    chk("stall_ctrl", 32'(ex_ctrl), 0);
    chk("stall_rd", 32'(ex_rd), 0);
    pc_keep = 0; if_id_keep = 0; id_ex_zero = 0;
    step();
    chk("resume_pc", pc, 32'h10C);
    chk("resume_instr", if_id_instr, 32'hA5A50108);
    chk("resume_ctrl", 32'(ex_ctrl), 32'h03);
    branch_taken = 1; branch_target = 32'h40;
    step();
    chk("br_pc", pc, 32'h40);
    chk("br_valid", 32'(if_id_valid), 0);
    chk("br_instr", if_id_instr, 0);
    chk("br_pc4", if_id_pc4, 0);
    branch_taken = 0;
    step();
    chk("br_next_pc", pc, 32'h44);
    chk("br_next_instr", if_id_instr, 32'hA5A50040);
    chk("br_next_ctrl", 32'(ex_ctrl), 0);
    pc_keep = 1; branch_taken = 1; branch_target = 32'h200;
    step();
    chk("keepbr_pc", pc, 32'h44);
    chk("keepbr_valid", 32'(if_id_valid), 0);
    pc_keep = 0; branch_taken = 0;
    step();
    chk("keepbr_next_pc", pc, 32'h48);
    chk("keepbr_next_instr", if_id_instr, 32'hA5A50044);
    imem_ready = 0;
    step();
    chk("w1_wait", 32'(fetch_wait), 1);
    chk("w1_pc", pc, 32'h48);
    chk("w1_valid", 32'(if_id_valid), 0);
    chk("w1_instr", if_id_instr, 0);
    step();
    chk("w2_wait", 32'(fetch_wait), 1);
    chk("w2_pc", pc, 32'h48);
    chk("w2_valid", 32'(if_id_valid), 0);
    imem_ready = 1;
    step();
    chk("w3_wait", 32'(fetch_wait), 0);
    chk("w3_pc", pc, 32'h4C);
    chk("w3_instr", if_id_instr, 32'hA5A50048);
    branch_taken = 1; branch_target = 32'hFFFFFFFC;
    step();
    chk("hi_pc", pc, 32'hFFFFFFFC);
    branch_taken = 0;
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'hA5A5FFFC);
    imem_ready = 0;
    step();
    chk("rw_wait", 32'(fetch_wait), 1);
    rst_n = 0;
    step();
    chk("rw_pc", pc, 32'h100);
    chk("rw_wait0", 32'(fetch_wait), 0);
    rst_n = 1; branch_taken = 1; branch_target = 32'h80;
    step();
    chk("brnr_pc", pc, 32'h80);
    chk("brnr_wait", 32'(fetch_wait), 0);
    branch_taken = 0; imem_ready = 1;
    step();
    id_ex_zero = 1;
    step();
    chk("zero_ctrl", 32'(ex_ctrl), 0);
    chk("zero_pc", pc, 32'h88);
    id_ex_zero = 0;
`ifdef FRONT_STALL_CNT_EN
    rst_n = 0;
    step();
    chk("cnt_rst", stall_cnt, 0);
    rst_n = 1; pc_keep = 1; if_id_keep = 1; id_ex_zero = 1;
    repeat (3) step();
    pc_keep = 0; if_id_keep = 0; id_ex_zero = 0; branch_taken = 1; branch_target = 32'h20;
    step();
    branch_taken = 0;
    chk("stall_cnt", stall_cnt, 3);
    chk("bubble_ge3", 32'(bubble_cnt >= 3), 1);
    chk("flush_cnt", flush_cnt, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
